audio_dac_serializer: RTL and testbench
=======================================

AUDIO_DAC_SERIALIZER -- requirements
Module: audio_dac_serializer

Interface
- REQ-001: Parameter AUDIO_DATA_WIDTH, default 32, bits per channel sample.
- REQ-002: Parameter FIFO_DEPTH, default 8, left/right sample pairs buffered; power of two, at least 2.
- REQ-003: CLOCK_50  in  1  system clock; the only clock; all logic on its rising edge.
- REQ-004: reset  in  1  synchronous, active-high reset.
- REQ-005: clear_audio_out_memory  in  1  synchronous FIFO flush.
- REQ-006: left_channel_audio_out  in  AUDIO_DATA_WIDTH  left sample, two's complement.
- REQ-007: right_channel_audio_out  in  AUDIO_DATA_WIDTH  right sample, two's complement.
- REQ-008: write_audio_out  in  1  push request for one left/right pair.
- REQ-009: audio_out_allowed  out  1  FIFO not full; a push is accepted only when this is high.
- REQ-010: AUD_BCLK  in  1  codec bit clock (codec is master), asynchronous.
- REQ-011: AUD_DACLRCK  in  1  codec frame clock (high = left), asynchronous.
- REQ-012: AUD_DACDAT  out  1  serial DAC data, registered.

Function
- REQ-013: AUD_BCLK and AUD_DACLRCK pass through two-flop synchronizers; edges are detected from the third registered stage.
- REQ-014: A push is taken when write_audio_out && audio_out_allowed in a cycle; the pair is stored atomically; a push while full is dropped with no state change.
- REQ-015: audio_out_allowed is registered, and it deasserts in the cycle after the push that fills the FIFO.
- REQ-016: State machine IDLE -> LEFT -> RIGHT -> LEFT...; IDLE exits to LEFT on the first detected LRCK rising edge after reset.
- REQ-017: On an LRCK rising edge, pop one pair (if not empty), load the left sample into the shift register and the right sample into the hold register, and drive the MSB on AUD_DACDAT the next cycle.
- REQ-018: On an LRCK falling edge, load the hold register into the shift register and drive its MSB the next cycle; this is left-justified format.
- REQ-019: On each detected BCLK falling edge after a load, shift left by one; after AUDIO_DATA_WIDTH bits, AUD_DACDAT is 0 until the next LRCK edge.
- REQ-020: If the FIFO is empty at an LRCK rising edge (underrun), both channels of that frame shift out all zeros.
- REQ-021: An LRCK edge arriving before all bits are sent aborts the current word and reloads.
- REQ-022: Simultaneous push and pop in one cycle are both performed and the count is unchanged; if the FIFO was full, the push is still dropped (per REQ-014).
- REQ-023: clear_audio_out_memory empties the FIFO next cycle, does not abort the word in flight, and takes priority over a simultaneous push.

Reset
- REQ-024: Reset clears FIFO pointers and count and sets state to IDLE.
- REQ-025: Reset clears the shift and hold registers; AUD_DACDAT = 0 and audio_out_allowed = 1 in the cycle after reset is sampled.
- REQ-026: Reset mid-word truncates immediately; serialization resumes only at the next LRCK rising edge.

Configuration
- REQ-027: Macro AUDIO_UNDERRUN_CNT_EN defined: add output underrun_count (16 bits), a saturating counter incremented once per REQ-020 event and cleared by reset or clear_audio_out_memory.
- REQ-028: Macro undefined: the port and counter are absent, and all other behaviour is identical.

Structure
- REQ-029: Package audio_out_pkg holds default width and depth constants, the serializer state enum, and the underrun counter width.
- REQ-030: Sub-module audio_out_fifo (synchronous, pair-wide, with count, full, empty and flush) is instantiated once.

Verification
- REQ-031: Push L=32'h8000_0001, R=32'h7FFF_FFFE with BCLK=CLOCK_50/16, LRCK=BCLK/64 -> AUD_DACDAT sends 1,0..0,1 in the left half, then 0,1..1,0 in the right half.
- REQ-032: Push 9 pairs with DEPTH=8 and no LRCK -> audio_out_allowed low after the 8th push, the 9th is dropped, and 8 pairs then play in order.
- REQ-033: Empty FIFO over 3 frames -> AUD_DACDAT constant 0; underrun_count=3 with the macro defined.
- REQ-034: Push on the same cycle as a pop with count=8 -> push dropped, count=7 afterwards, allowed high the following cycle.
- REQ-035: Assert reset at bit 10 of a left word -> AUD_DACDAT=0 next cycle, silence until the next LRCK rise, allowed=1.
- REQ-036: Assert clear_audio_out_memory with 5 queued pairs during a right word -> the right word completes, then the next frame is zeros (underrun).

Source files
------------

// File: rtl/audio_out_pkg.sv
// Shared constants, serializer state encoding and small helpers for the
// audio DAC output path.
package audio_out_pkg;

  localparam int AUDIO_DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH_DEF       = 8;
  localparam int UNDERRUN_CNT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } ser_state_e;

  function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] v);
    if (&v) begin
      sat_inc = v;
    end else begin
      sat_inc = v + UNDERRUN_CNT_W'(1);
    end
  endfunction

endpackage

// File: rtl/audio_out_fifo.sv
// Pair-wide synchronous FIFO with flush, occupancy count and registered
// empty / not-full flags.
module audio_out_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   not_full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             empty_q, not_full_q;
  logic             do_push_s, do_pop_s;

  assign do_push_s = push_i && not_full_q && !flush_i;
  assign do_pop_s  = pop_i && !empty_q && !flush_i;

  // Next pointers and occupancy; a flush overrides any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push_s) wr_ptr_d = wr_ptr_q + AW'(1);
      else           wr_ptr_d = wr_ptr_q;
      if (do_pop_s)  rd_ptr_d = rd_ptr_q + AW'(1);
      else           rd_ptr_d = rd_ptr_q;
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer, count and status flag registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      not_full_q <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      not_full_q <= (count_d != (AW+1)'(DEPTH));
    end
  end

  // Sample storage; contents are only consumed behind the empty flag.
  always_ff @(posedge clk_i) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o    = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = empty_q;
  assign not_full_o = not_full_q;

endmodule

// File: rtl/audio_dac_serializer.sv
// Left-justified audio DAC serializer slaved to codec BCLK/LRCK.
// Optional underrun counter enabled by defining AUDIO_UNDERRUN_CNT_EN.
module audio_dac_serializer
  import audio_out_pkg::*;
#(
  parameter int AUDIO_DATA_WIDTH = AUDIO_DATA_WIDTH_DEF,
  parameter int FIFO_DEPTH       = FIFO_DEPTH_DEF
) (
  input  logic                        CLOCK_50,
  input  logic                        reset,
  input  logic                        clear_audio_out_memory,
  input  logic [AUDIO_DATA_WIDTH-1:0] left_channel_audio_out,
  input  logic [AUDIO_DATA_WIDTH-1:0] right_channel_audio_out,
  input  logic                        write_audio_out,
  output logic                        audio_out_allowed,
  input  logic                        AUD_BCLK,
  input  logic                        AUD_DACLRCK,
  output logic                        AUD_DACDAT
`ifdef AUDIO_UNDERRUN_CNT_EN
  , output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);
  localparam int W      = AUDIO_DATA_WIDTH;
  localparam int BITS_W = $clog2(W + 1);

  logic [2:0] bclk_sync_q, lrck_sync_q;
  logic       bclk_fall_s, lrck_rise_s, lrck_fall_s;

  logic [2*W-1:0]              fifo_rdata_s;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
  logic                        fifo_empty_s, fifo_not_full_s, frame_empty_s;

  ser_state_e        state_q;
  logic [W-1:0]      shift_q, hold_q, shift_nx_s;
  logic [BITS_W-1:0] bits_q;
  logic              dout_q;

  // Synchronizers carry no reset so a reset never fakes an LRCK edge.
  always_ff @(posedge CLOCK_50) begin
    bclk_sync_q <= {bclk_sync_q[1:0], AUD_BCLK};
    lrck_sync_q <= {lrck_sync_q[1:0], AUD_DACLRCK};
  end

  assign bclk_fall_s   = bclk_sync_q[2] & ~bclk_sync_q[1];
  assign lrck_rise_s   = ~lrck_sync_q[2] & lrck_sync_q[1];
  assign lrck_fall_s   = lrck_sync_q[2] & ~lrck_sync_q[1];
  assign frame_empty_s = (fifo_count_s == '0);
  assign shift_nx_s    = {shift_q[W-2:0], 1'b0};

  audio_out_fifo #(
    .WIDTH (2 * W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLOCK_50),
    .rst_i      (reset),
    .flush_i    (clear_audio_out_memory),
    .push_i     (write_audio_out && fifo_not_full_s),
    .pop_i      (lrck_rise_s && !fifo_empty_s),
    .wdata_i    ({left_channel_audio_out, right_channel_audio_out}),
    .rdata_o    (fifo_rdata_s),
    .count_o    (fifo_count_s),
    .empty_o    (fifo_empty_s),
    .not_full_o (fifo_not_full_s)
  );

  // Serializer FSM: frame alignment, word loads and MSB-first shifting.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      hold_q  <= '0;
      bits_q  <= '0;
      dout_q  <= 1'b0;
    end else if (lrck_rise_s) begin
      state_q <= ST_LEFT;
      bits_q  <= BITS_W'(1);
      if (frame_empty_s) begin
        shift_q <= '0;
        hold_q  <= '0;
        dout_q  <= 1'b0;
      end else begin
        shift_q <= fifo_rdata_s[2*W-1:W];
        hold_q  <= fifo_rdata_s[W-1:0];
        dout_q  <= fifo_rdata_s[2*W-1];
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
        end
        ST_LEFT, ST_RIGHT: begin
          if (lrck_fall_s && state_q == ST_LEFT) begin
            state_q <= ST_RIGHT;
            shift_q <= hold_q;
            dout_q  <= hold_q[W-1];
            bits_q  <= BITS_W'(1);
          end else if (bclk_fall_s) begin
            // Once the whole word has been presented the line idles low.
            if (bits_q < BITS_W'(W)) begin
              shift_q <= shift_nx_s;
              dout_q  <= shift_nx_s[W-1];
              bits_q  <= bits_q + BITS_W'(1);
            end else begin
              dout_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          dout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign AUD_DACDAT        = dout_q;
  assign audio_out_allowed = fifo_not_full_s;

`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [UNDERRUN_CNT_W-1:0] underrun_q;

  // Saturating count of frames started with an empty FIFO.
  always_ff @(posedge CLOCK_50) begin
    if (reset || clear_audio_out_memory) begin
      underrun_q <= '0;
    end else if (lrck_rise_s && frame_empty_s) begin
      underrun_q <= sat_inc(underrun_q);
    end
  end

  assign underrun_count = underrun_q;
`endif

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: a behavioural codec drives
// BCLK/LRCK while a queue-based frame model predicts every sampled bit.
module tb_audio_dac_serializer;
  localparam int W     = 32;
  localparam int DEPTH = 8;

  logic         CLOCK_50 = 1'b0;
  logic         reset, clear_audio_out_memory, write_audio_out;
  logic [W-1:0] left_s, right_s;
  logic         audio_out_allowed, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;
`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [15:0]  underrun_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  audio_dac_serializer #(
    .AUDIO_DATA_WIDTH (W),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .CLOCK_50                (CLOCK_50),
    .reset                   (reset),
    .clear_audio_out_memory  (clear_audio_out_memory),
    .left_channel_audio_out  (left_s),
    .right_channel_audio_out (right_s),
    .write_audio_out         (write_audio_out),
    .audio_out_allowed       (audio_out_allowed),
    .AUD_BCLK                (AUD_BCLK),
    .AUD_DACLRCK             (AUD_DACLRCK),
    .AUD_DACDAT              (AUD_DACDAT)
`ifdef AUDIO_UNDERRUN_CNT_EN
    , .underrun_count        (underrun_count)
`endif
  );

  // Reference model: queued pairs, word currently on the line, frame geometry.
  logic [W-1:0] q_l[$];
  logic [W-1:0] q_r[$];
  logic [W-1:0] cur_word, hold_word;
  bit           silent;
  int           model_underruns;
  int           ph;
  int           last_ph;
  int           hb;

  // One system-clock step of the codec; BCLK = CLOCK_50/16, hb BCLKs per half frame.
  task automatic codec_step();
    @(negedge CLOCK_50);
    AUD_BCLK    = ((ph % 16) >= 8) ? 1'b1 : 1'b0;
    AUD_DACLRCK = (ph < hb * 16) ? 1'b1 : 1'b0;
    if (ph == 0) begin
      if (q_l.size() > 0) begin
        cur_word  = q_l.pop_front();
        hold_word = q_r.pop_front();
      end else begin
        cur_word  = '0;
        hold_word = '0;
        model_underruns++;
      end
      silent = 1'b0;
    end else if (ph == hb * 16) begin
      cur_word = hold_word;
    end
    last_ph = ph;
    ph = (ph + 1) % (hb * 32);
  endtask

  function automatic logic exp_bit(input int p);
    int k;
    k = (p % (hb * 16)) / 16;
    if (silent || k >= W) return 1'b0;
    return cur_word[W-1-k];
  endfunction

  task automatic push_idle(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge CLOCK_50);
    left_s = l;
    right_s = r;
    write_audio_out = 1'b1;
    if (q_l.size() < DEPTH) begin
      q_l.push_back(l);
      q_r.push_back(r);
    end
    @(negedge CLOCK_50);
    write_audio_out = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge CLOCK_50);
    reset = 1'b0;
    q_l.delete(); q_r.delete();
    silent = 1'b1;
    model_underruns = 0;
    @(negedge CLOCK_50);
    checks++;
    if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL reset_dat: got %b want 0", AUD_DACDAT); end
    checks++;
    if (audio_out_allowed !== 1'b1) begin errors++; $display("FAIL reset_allowed: got %b want 1", audio_out_allowed); end
  endtask

  task automatic test_underrun();
    int ones;
    ones = 0;
    for (int s = 0; s < 3 * hb * 32; s++) begin
      codec_step();
      if (AUD_DACDAT !== 1'b0) ones++;
    end
    checks++;
    if (ones != 0) begin errors++; $display("FAIL underrun_silence: got %0d high cycles want 0", ones); end
`ifdef AUDIO_UNDERRUN_CNT_EN
    checks++;
    if (underrun_count !== 16'd3) begin errors++; $display("FAIL underrun_count: got %0d want 3", underrun_count); end
`endif
  endtask

  task automatic test_known_pattern();
    logic [W-1:0] got_l, got_r;
    int k;
    got_l = '0; got_r = '0;
    push_idle(32'h8000_0001, 32'h7FFF_FFFE);
    for (int s = 0; s < hb * 32; s++) begin
      codec_step();
      if (last_ph % 16 == 8) begin
        k = (last_ph % (hb * 16)) / 16;
        if (last_ph < hb * 16) got_l[W-1-k] = AUD_DACDAT;
        else                   got_r[W-1-k] = AUD_DACDAT;
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL known_bit ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
    checks++;
    if (got_l !== 32'h8000_0001) begin errors++; $display("FAIL known_left: got %h want 80000001", got_l); end
    checks++;
    if (got_r !== 32'h7FFF_FFFE) begin errors++; $display("FAIL known_right: got %h want 7ffffffe", got_r); end
  endtask

  task automatic test_fill_overflow();
    logic exp_allowed;
    for (int i = 0; i < 9; i++) begin
      push_idle($urandom, $urandom);
      exp_allowed = (q_l.size() < DEPTH) ? 1'b1 : 1'b0;
      checks++;
      if (audio_out_allowed !== exp_allowed) begin
        errors++; $display("FAIL fill_allowed push=%0d: got %b want %b", i + 1, audio_out_allowed, exp_allowed);
      end
    end
    for (int s = 0; s < 9 * hb * 32; s++) begin
      codec_step();
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL fill_bit ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
  endtask

  task automatic test_simul_push_pop();
    for (int i = 0; i < DEPTH; i++) push_idle($urandom, $urandom);
    for (int s = 0; s < hb * 32; s++) begin
      codec_step();
      if (last_ph == 2) begin
        checks++;
        if (audio_out_allowed !== 1'b0) begin errors++; $display("FAIL simul_full: got %b want 0", audio_out_allowed); end
        left_s = 32'hDEAD_BEEF;
        right_s = 32'hCAFE_F00D;
        write_audio_out = 1'b1;
      end else if (last_ph == 3) begin
        write_audio_out = 1'b0;
        checks++;
        if (audio_out_allowed !== 1'b1) begin errors++; $display("FAIL simul_allowed: got %b want 1", audio_out_allowed); end
      end
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL simul_bit ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
    push_idle($urandom, $urandom);
    checks++;
    if (audio_out_allowed !== 1'b0) begin errors++; $display("FAIL simul_count7: got %b want 0", audio_out_allowed); end
    for (int s = 0; s < DEPTH * hb * 32; s++) begin
      codec_step();
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL simul_order ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [W-1:0] l, r;
    push_idle($urandom, $urandom);
    push_idle($urandom, $urandom);
    for (int s = 0; s < 2 * hb * 32; s++) begin
      codec_step();
      if (s < hb * 32 && last_ph == 10 * 16 + 9) begin
        reset = 1'b1;
        q_l.delete(); q_r.delete();
        silent = 1'b1;
        model_underruns = 0;
      end else if (reset) begin
        reset = 1'b0;
        checks++;
        if (AUD_DACDAT !== 1'b0) begin errors++; $display("FAIL midreset_dat: got %b want 0", AUD_DACDAT); end
        checks++;
        if (audio_out_allowed !== 1'b1) begin errors++; $display("FAIL midreset_allowed: got %b want 1", audio_out_allowed); end
      end
      if (s < hb * 32 && last_ph == 700) begin
        l = $urandom; r = $urandom;
        left_s = l; right_s = r;
        write_audio_out = 1'b1;
        q_l.push_back(l); q_r.push_back(r);
      end else if (s < hb * 32 && last_ph == 701) begin
        write_audio_out = 1'b0;
      end
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL midreset_bit ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
  endtask

  task automatic test_clear_mid_right();
    for (int i = 0; i < 5; i++) push_idle($urandom, $urandom);
    for (int s = 0; s < 2 * hb * 32; s++) begin
      codec_step();
      if (s < hb * 32 && last_ph == hb * 16 + 100) begin
        clear_audio_out_memory = 1'b1;
        q_l.delete(); q_r.delete();
        model_underruns = 0;
      end else if (clear_audio_out_memory) begin
        clear_audio_out_memory = 1'b0;
        checks++;
        if (audio_out_allowed !== 1'b1) begin errors++; $display("FAIL clear_allowed: got %b want 1", audio_out_allowed); end
      end
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL clear_bit ph=%0d: got %b want %b", last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
`ifdef AUDIO_UNDERRUN_CNT_EN
    checks++;
    if (underrun_count !== 16'(model_underruns)) begin
      errors++; $display("FAIL clear_underruns: got %0d want %0d", underrun_count, model_underruns);
    end
`endif
  endtask

  task automatic test_random_stream(input int half_bclks, input int pairs, input int frames);
    hb = half_bclks;
    for (int i = 0; i < pairs; i++) push_idle($urandom, $urandom);
    for (int s = 0; s < frames * hb * 32; s++) begin
      codec_step();
      if (last_ph % 16 == 8) begin
        checks++;
        if (AUD_DACDAT !== exp_bit(last_ph)) begin
          errors++; $display("FAIL stream_hb%0d_bit ph=%0d: got %b want %b", hb, last_ph, AUD_DACDAT, exp_bit(last_ph));
        end
      end
    end
`ifdef AUDIO_UNDERRUN_CNT_EN
    checks++;
    if (underrun_count !== 16'(model_underruns)) begin
      errors++; $display("FAIL stream_underruns: got %0d want %0d", underrun_count, model_underruns);
    end
`endif
  endtask

  initial begin
    reset = 1'b0;
    clear_audio_out_memory = 1'b0;
    write_audio_out = 1'b0;
    left_s = '0;
    right_s = '0;
    AUD_BCLK = 1'b0;
    AUD_DACLRCK = 1'b0;
    cur_word = '0;
    hold_word = '0;
    silent = 1'b1;
    model_underruns = 0;
    ph = 0;
    last_ph = 0;
    hb = 32;

    test_reset();
    test_underrun();
    test_known_pattern();
    test_fill_overflow();
    test_simul_push_pop();
    test_reset_mid_word();
    test_clear_mid_right();
    test_random_stream(40, 5, 6);
    test_random_stream(24, 3, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
